// File: rtl/adc_spi_responder.sv
// Serial-clocked model of an 8-channel 12-bit SPI ADC (ADC128S022-style framing).
// The address decoded in one frame selects the sample returned in the next.
module adc_spi_responder #(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 16
) (
  input  logic                     c1m,
  input  logic                     rst_n,
  input  logic                     CS_n,
  input  logic                     DIN,
  output logic                     DOUT,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     pattern_en,
  output logic                     frame_done,
  output logic [2:0]               last_addr,
  output logic [8:0]               frame_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LEAD_BITS = CNT_W'(FRAME_LEN - DATA_W);

  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_idx;
  logic [2:0]        addr_next;
  logic [2:0]        addr_cur;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] load_word;
  logic [2:0]        load_addr;
  logic [8:0]        load_cnt;
  logic [8:0]        frame_cnt_inc;
  logic              frame_end;
  logic              dout_next;

  // One load path serves both the end-of-frame load and the idle reload.
  always_comb begin
    frame_end     = !CS_n && (bit_cnt == LAST_BIT);
    frame_cnt_inc = frame_cnt + 9'd1;
    load_addr     = frame_end ? addr_next : addr_cur;
    load_cnt      = frame_end ? frame_cnt_inc : frame_cnt;
    load_word     = '0;
    if (pattern_en) begin
      load_word = DATA_W'({load_addr, load_cnt});
    end else if (int'(load_addr) < NUM_CH) begin
      load_word = ch_data[int'(load_addr)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge c1m or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      addr_next  <= '0;
      addr_cur   <= '0;
      shift_reg  <= '0;
      frame_cnt  <= '0;
      last_addr  <= '0;
      frame_done <= 1'b0;
    end else if (CS_n) begin
      bit_cnt    <= '0;
      addr_next  <= '0;
      shift_reg  <= load_word;
      frame_done <= 1'b0;
    end else begin
      bit_cnt    <= frame_end ? '0 : bit_cnt + 1'b1;
      frame_done <= frame_end;
      if (bit_cnt == CNT_W'(2)) addr_next[2] <= DIN;
      if (bit_cnt == CNT_W'(3)) addr_next[1] <= DIN;
      if (bit_cnt == CNT_W'(4)) addr_next[0] <= DIN;
      if (frame_end) begin
        addr_cur  <= addr_next;
        last_addr <= addr_next;
        frame_cnt <= frame_cnt_inc;
        shift_reg <= load_word;
      end
    end
  end

  // Word is held static during the frame and indexed by position, MSB at p=4.
  always_comb begin
    bit_idx   = LAST_BIT - bit_cnt;
    dout_next = 1'b0;
    if (!CS_n && (bit_cnt >= LEAD_BITS)) begin
      dout_next = shift_reg[bit_idx];
    end
  end

  always_ff @(negedge c1m or negedge rst_n) begin
    if (!rst_n) begin
      DOUT <= 1'b0;
    end else begin
      DOUT <= dout_next;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: framing, pipeline latency, test pattern,
// aborted frame, mid-frame reset and frame counter wrap.
module tb_adc_spi_responder;

  logic        c1m = 1'b0;
  logic        rst_n;
  logic        CS_n;
  logic        DIN;
  logic        DOUT;
  logic [95:0] ch_data;
  logic        pattern_en;
  logic        frame_done;
  logic [2:0]  last_addr;
  logic [8:0]  frame_cnt;

  int checks   = 0;
  int failures = 0;

  adc_spi_responder #(.NUM_CH(8), .DATA_W(12), .FRAME_LEN(16)) dut (
    .c1m        (c1m),
    .rst_n      (rst_n),
    .CS_n       (CS_n),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .ch_data    (ch_data),
    .pattern_en (pattern_en),
    .frame_done (frame_done),
    .last_addr  (last_addr),
    .frame_cnt  (frame_cnt)
  );

  always #5 c1m = ~c1m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts just after a negedge; non-address DIN positions carry 1s to prove they are ignored.
  task automatic run_bits(input logic [2:0] addr, input int nbits,
                          output logic [15:0] word, output int dones);
    word  = '0;
    dones = 0;
    for (int i = 0; i < nbits; i++) begin
      DIN = (i == 2) ? addr[2] : (i == 3) ? addr[1] : (i == 4) ? addr[0] : 1'b1;
      @(posedge c1m);
      word = {word[14:0], DOUT};
      @(negedge c1m);
      #1;
      if (frame_done) dones++;
    end
  endtask

  logic [15:0] w;
  int          d;
  int          total_done;

  initial begin
    rst_n = 1'b0;
    CS_n  = 1'b1;
    DIN   = 1'b0;
    pattern_en = 1'b0;
    ch_data = '0;
    ch_data[0*12 +: 12] = 12'hA5C;
    ch_data[2*12 +: 12] = 12'h123;
    ch_data[3*12 +: 12] = 12'h456;
    ch_data[5*12 +: 12] = 12'h3F0;
    ch_data[7*12 +: 12] = 12'h7E7;
    #2;
    check("rst_dout", 32'(DOUT), 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst_last_addr", 32'(last_addr), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    #10 rst_n = 1'b1;
    repeat (3) @(negedge c1m);
    #1;
    check("idle_dout", 32'(DOUT), 32'h0);
    CS_n = 1'b0;

    // F1: returns channel 0, sends address 5
    run_bits(3'd5, 16, w, d);
    check("f1_word", 32'(w), 32'h0A5C);
    check("f1_done", 32'(d), 32'd1);
    check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f1_last_addr", 32'(last_addr), 32'd5);

    // Source changes after the load must not disturb the word in flight
    pattern_en = 1'b1;
    ch_data[5*12 +: 12] = 12'h000;
    run_bits(3'd7, 16, w, d);
    check("f2_word", 32'(w), 32'h03F0);
    check("f2_done", 32'(d), 32'd1);
    check("f2_last_addr", 32'(last_addr), 32'd7);

    run_bits(3'd7, 16, w, d);
    check("f3_pattern_word", 32'(w), 32'h0E02);
    pattern_en = 1'b0;
    run_bits(3'd2, 16, w, d);
    check("f4_pattern_word", 32'(w), 32'h0E03);
    check("f4_frame_cnt", 32'(frame_cnt), 32'd4);

    run_bits(3'd3, 16, w, d);
    check("f5_word", 32'(w), 32'h0123);
    check("f5_last_addr", 32'(last_addr), 32'd3);

    // Abort with address 2 captured, CS_n raised at bit_cnt=8
    run_bits(3'd2, 8, w, d);
    CS_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge c1m);
      #1;
      check("abort_dout", 32'(DOUT), 32'h0);
      check("abort_done", 32'(frame_done), 32'h0);
    end
    check("abort_frame_cnt", 32'(frame_cnt), 32'd5);
    check("abort_last_addr", 32'(last_addr), 32'd3);
    ch_data[0*12 +: 12] = 12'hFFF;
    CS_n = 1'b0;
    run_bits(3'd0, 16, w, d);
    check("f7_prior_channel", 32'(w), 32'h0456);
    check("f7_frame_cnt", 32'(frame_cnt), 32'd6);

    // Reset asserted at bit_cnt=10 while 0xFFF is in flight
    run_bits(3'd1, 10, w, d);
    check("pre_reset_dout", 32'(DOUT), 32'h1);
    rst_n = 1'b0;
    CS_n  = 1'b1;
    #1;
    check("mid_reset_dout", 32'(DOUT), 32'h0);
    check("mid_reset_frame_cnt", 32'(frame_cnt), 32'h0);
    check("mid_reset_last_addr", 32'(last_addr), 32'h0);
    ch_data[0*12 +: 12] = 12'h5A3;
    #1 rst_n = 1'b1;
    repeat (2) @(negedge c1m);
    #1;
    CS_n = 1'b0;
    run_bits(3'd0, 16, w, d);
    check("post_reset_word", 32'(w), 32'h05A3);
    check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);
    total_done = d;

    // Remaining frames up to 512 since reset
    for (int f = 0; f < 510; f++) begin
      run_bits(3'd0, 16, w, d);
      total_done += d;
    end
    check("cnt_511", 32'(frame_cnt), 32'd511);
    check("loop_word", 32'(w), 32'h05A3);
    run_bits(3'd0, 16, w, d);
    total_done += d;
    check("cnt_wrap", 32'(frame_cnt), 32'd0);
    check("done_total", 32'(total_done), 32'd512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
